clk_div_multi: RTL and testbench

- Parametrised multi-channel clock divider for the board-level clock tree; successor to the fixed single-output divider.
- Each channel produces:
  - a divided square wave, used as a fabric signal, never as a real clock;
  - a one-cycle tick enable, the preferred way to time slow logic.
- Each channel's divisor can be reprogrammed at run time. Updates are glitch-free at period boundaries, and all channels can be phase-aligned by a common sync clear.

---
 rtl/clk_div_pkg.sv | 17 +
 rtl/clk_div_chan.sv | 82 ++++++++
 rtl/clk_div_multi.sv | 52 +++++
 tb/tb_clk_div_multi.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared defaults, channel-select width helper and channel flag types
package clk_div_pkg;

  localparam int DEFAULT_WIDTH   = 24;
  localparam int DEFAULT_DIV_VAL = 8388607;

  function automatic int calc_chw(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

  typedef struct packed {
    logic pending;
    logic clk_out;
    logic tick;
  } chan_flags_t;

endpackage

// File: rtl/clk_div_chan.sv
// rtl/clk_div_chan.sv - one divider channel: counter, shadow divisor and registered outputs
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] DEFAULT_DIV = WIDTH'(DEFAULT_DIV_VAL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clear,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_div,
  output logic             clk_out,
  output logic             tick,
  output logic             pending
);

  typedef struct packed {
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] active_div;
    logic [WIDTH-1:0] shadow_div;
    chan_flags_t      f;
  } chan_state_t;

  chan_state_t cur, nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur.cnt        <= '0;
      cur.active_div <= DEFAULT_DIV;
      cur.shadow_div <= DEFAULT_DIV;
      cur.f          <= '0;
    end else begin
      cur <= nxt;
    end
  end

  always_comb begin
    nxt        = cur;
    nxt.f.tick = 1'b0;
    if (!en || sync_clear) begin
      nxt.cnt       = '0;
      nxt.f.clk_out = 1'b0;
      if (cur.f.pending) begin
        nxt.active_div = cur.shadow_div;
        nxt.f.pending  = 1'b0;
      end
      if (wr) begin
        nxt.shadow_div = wr_div;
        // A stopped channel has no period boundary to wait for, so the value lands now.
        if (en) begin
          nxt.f.pending = 1'b1;
        end else begin
          nxt.active_div = wr_div;
          nxt.f.pending  = 1'b0;
        end
      end
    end else begin
      if (cur.cnt == cur.active_div) begin
        nxt.cnt       = '0;
        nxt.f.clk_out = ~cur.f.clk_out;
        nxt.f.tick    = ~cur.f.clk_out;
        if (cur.f.pending) begin
          nxt.active_div = cur.shadow_div;
          nxt.f.pending  = 1'b0;
        end
      end else begin
        nxt.cnt = cur.cnt + 1'b1;
      end
      if (wr) begin
        nxt.shadow_div = wr_div;
        nxt.f.pending  = 1'b1;
      end
    end
  end

  assign clk_out = cur.f.clk_out;
  assign tick    = cur.f.tick;
  assign pending = cur.f.pending;

endmodule

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel clock divider top: config decode, error pulse, channel array
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int          CHANNELS    = 4,
  parameter int          WIDTH       = DEFAULT_WIDTH,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_VAL,
  parameter int          CHW         = calc_chw(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] en,
  input  logic                sync_clear,
  input  logic                cfg_we,
  input  logic [CHW-1:0]      cfg_ch,
  input  logic [WIDTH-1:0]    cfg_div,
  output logic                cfg_err,
  output logic [CHANNELS-1:0] clk_out,
  output logic [CHANNELS-1:0] tick,
  output logic [CHANNELS-1:0] pending
);

  logic [CHANNELS-1:0] wr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && (32'(cfg_ch) >= 32'(CHANNELS));
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    assign wr[i] = cfg_we && (cfg_ch == CHW'(i));

    clk_div_chan #(
      .WIDTH       (WIDTH),
      .DEFAULT_DIV (WIDTH'(DEFAULT_DIV))
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .en         (en[i]),
      .sync_clear (sync_clear),
      .wr         (wr[i]),
      .wr_div     (cfg_div),
      .clk_out    (clk_out[i]),
      .tick       (tick[i]),
      .pending    (pending[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - directed, table-driven bench for clk_div_multi (3 channels, default divisor 3)
module tb_clk_div_multi;

  localparam int CH = 3;
  localparam int W  = 24;

  logic          clk = 1'b0;
  logic          rst;
  logic [CH-1:0] en;
  logic          sync_clear;
  logic          cfg_we;
  logic [1:0]    cfg_ch;
  logic [W-1:0]  cfg_div;
  logic          cfg_err;
  logic [CH-1:0] clk_out;
  logic [CH-1:0] tick;
  logic [CH-1:0] pending;

  int n_cmp = 0;
  int n_err = 0;

  clk_div_multi #(
    .CHANNELS    (CH),
    .WIDTH       (W),
    .DEFAULT_DIV (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .sync_clear (sync_clear),
    .cfg_we     (cfg_we),
    .cfg_ch     (cfg_ch),
    .cfg_div    (cfg_div),
    .cfg_err    (cfg_err),
    .clk_out    (clk_out),
    .tick       (tick),
    .pending    (pending)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic en;
    logic exp_clk;
    logic exp_tick;
  } vec_t;

  vec_t vecs[22];

  task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s k=%0d: got %0h expected %0h", name, k, act, exp);
    end
  endtask

  function automatic logic bit_of(input string s, input int k);
    return s.substr(k - 1, k - 1) == "1";
  endfunction

  task automatic wr_cfg(input int ch, input int div);
    cfg_we  = 1'b1;
    cfg_ch  = 2'(ch);
    cfg_div = W'(div);
    @(negedge clk);
    cfg_we  = 1'b0;
  endtask

  // Follows one channel for n cycles; optionally issues a write right after sampling cycle wr_k.
  task automatic observe(input string name, input int ch, input int n, input string cs,
                         input string ts, input string ps, input int wr_k, input int wdiv);
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      cfg_we = 1'b0;
      check({name, "_clk"}, k, 32'(clk_out[ch]), 32'(bit_of(cs, k)));
      check({name, "_tick"}, k, 32'(tick[ch]), 32'(bit_of(ts, k)));
      check({name, "_pend"}, k, 32'(pending[ch]), 32'(bit_of(ps, k)));
      if (k == wr_k) begin
        cfg_we  = 1'b1;
        cfg_ch  = 2'(ch);
        cfg_div = W'(wdiv);
      end
    end
    cfg_we = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    string s1_clk, s1_tick, zeros20;
    s1_clk  = "00011110000111100001";
    s1_tick = "00010000000100000001";
    zeros20 = "00000000000000000000";

    rst = 1'b1; en = '0; sync_clear = 1'b0; cfg_we = 1'b0; cfg_ch = '0; cfg_div = '0;
    repeat (2) @(negedge clk);
    check("rst_clk_out", 0, 32'(clk_out), 0);
    check("rst_tick", 0, 32'(tick), 0);
    check("rst_pending", 0, 32'(pending), 0);
    check("rst_cfg_err", 0, 32'(cfg_err), 0);
    rst = 1'b0;
    @(negedge clk);

    // Default divisor 3: rise on cycle 4, period 8, then disable.
    for (int i = 0; i < 20; i++) begin
      vecs[i].en       = 1'b1;
      vecs[i].exp_clk  = bit_of(s1_clk, i + 1);
      vecs[i].exp_tick = bit_of(s1_tick, i + 1);
    end
    vecs[20] = '{en: 1'b0, exp_clk: 1'b0, exp_tick: 1'b0};
    vecs[21] = '{en: 1'b0, exp_clk: 1'b0, exp_tick: 1'b0};
    for (int i = 0; i < 22; i++) begin
      en[0] = vecs[i].en;
      @(negedge clk);
      check("s1_clk", i + 1, 32'(clk_out[0]), 32'(vecs[i].exp_clk));
      check("s1_tick", i + 1, 32'(tick[0]), 32'(vecs[i].exp_tick));
    end

    // Channel 1: N=3, write 1 mid high phase; current phase finishes at 4, then 2-cycle phases.
    en = 3'b010;
    observe("s2", 1, 14, "00011110011001", "00010000010001", "00000110000000", 5, 1);

    // Channel 2: N=2, write 5 landing on the terminal-count cycle.
    en = 3'b000;
    @(negedge clk);
    wr_cfg(2, 2);
    check("s3_disabled_wr_pend", 0, 32'(pending[2]), 0);
    en = 3'b100;
    observe("s3", 2, 22, "0011100011111100000011", "0010000010000000000010",
            "0000011100000000000000", 5, 5);

    // Channels 0/2 at N=4/N=2 free-running, then sync_clear.
    en = 3'b000;
    @(negedge clk);
    wr_cfg(0, 4);
    wr_cfg(2, 2);
    check("s4_pend_after_disabled_wr", 0, 32'(pending), 0);
    en = 3'b101;
    repeat (7) @(negedge clk);
    sync_clear = 1'b1;
    @(negedge clk);
    sync_clear = 1'b0;
    check("s4_sync_clk", 0, 32'(clk_out), 0);
    check("s4_sync_tick", 0, 32'(tick), 0);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check("s4_ch2_clk", k, 32'(clk_out[2]), 32'(bit_of("001110", k)));
      check("s4_ch0_clk", k, 32'(clk_out[0]), 32'(bit_of("000011", k)));
    end

    // Write to nonexistent channel 3.
    wr_cfg(3, 0);
    check("s5_cfg_err_pulse", 0, 32'(cfg_err), 1);
    check("s5_pending", 0, 32'(pending), 0);
    @(negedge clk);
    check("s5_cfg_err_clear", 1, 32'(cfg_err), 0);
    check("s5_pending_after", 1, 32'(pending), 0);

    // Reset while channel 0 is high with a pending divisor.
    begin
      int waited;
      waited = 0;
      while (!tick[0] && waited < 30) begin
        @(negedge clk);
        waited++;
      end
      check("s6_wait_tick", waited, 32'(tick[0]), 1);
    end
    wr_cfg(0, 1);
    check("s6_pre_pend", 0, 32'(pending[0]), 1);
    check("s6_pre_clk", 0, 32'(clk_out[0]), 1);
    rst = 1'b1;
    #1;
    check("s6_rst_clk", 0, 32'(clk_out), 0);
    check("s6_rst_tick", 0, 32'(tick), 0);
    check("s6_rst_pend", 0, 32'(pending), 0);
    en = 3'b001;
    @(negedge clk);
    rst = 1'b0;
    observe("s6", 0, 20, s1_clk, s1_tick, zeros20, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
